// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard controller: operand forwarding
// selects and the memory-wait FSM states.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EX = 2'd1,
        FWD_WB = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_match.sv
// Per-operand dependency check against the EX and WB stages; produces the
// EX match (for load-use detection) and the forwarding select.
module hazard_match
    import pipeline_pkg::*;
#(
    parameter int REG_ADDRESS_LENGTH = 5,
    parameter bit R0_ZERO            = 1'b1
) (
    input  logic                          used,
    input  logic [REG_ADDRESS_LENGTH-1:0] src,
    input  logic                          ex_valid,
    input  logic                          ex_wr_en,
    input  logic [REG_ADDRESS_LENGTH-1:0] ex_rd,
    input  logic                          wb_valid,
    input  logic                          wb_wr_en,
    input  logic [REG_ADDRESS_LENGTH-1:0] wb_rd,
    output logic                          ex_match,
    output fwd_sel_e                      fwd_sel
);

    logic src_live;
    logic wb_match;

    // A hard-wired zero register never carries a dependency.
    assign src_live = used & ~(R0_ZERO & (src == '0));
    assign ex_match = src_live & ex_valid & ex_wr_en & (ex_rd == src);
    assign wb_match = src_live & wb_valid & wb_wr_en & (wb_rd == src);

    always_comb begin
        fwd_sel = FWD_RF;
        if (ex_match) begin
            fwd_sel = FWD_EX;
        end else if (wb_match) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, stall and flush controller for the 4-stage core: tracks EX/WB
// occupancy, forwards from EX/WB, interlocks load-use and slow memory.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_ADDRESS_LENGTH = 5,
    parameter int LOAD_LATENCY       = 0,
    parameter bit R0_ZERO            = 1'b1,
    parameter int MEM_TIMEOUT        = 64,
    parameter int STALL_CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_ra,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rb,
    input  logic                          id_ra_used,
    input  logic                          id_rb_used,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rd,
    input  logic                          id_wr_en,
    input  logic                          id_is_load,
    input  logic                          id_is_mem,
    input  logic                          br_taken,
    input  logic                          mem_ready,
    output logic                          pc_en,
    output logic                          ifid_en,
    output logic                          idex_en,
    output logic                          ifid_flush,
    output logic                          idex_bubble,
    output logic                          exwb_bubble,
    output logic                          br_commit,
    output logic [1:0]                    fwd_a_sel,
    output logic [1:0]                    fwd_b_sel,
    output logic                          err,
    output logic [STALL_CNT_W-1:0]        stall_cycles
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    hz_state_e                     state_q, state_d;
    logic [WAIT_W-1:0]             wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
    logic                          ex_valid_q, ex_valid_d;
    logic [REG_ADDRESS_LENGTH-1:0] ex_rd_q, ex_rd_d;
    logic                          ex_wr_en_q, ex_wr_en_d;
    logic                          ex_is_load_q, ex_is_load_d;
    logic                          ex_is_mem_q, ex_is_mem_d;
    logic                          ex_age_q, ex_age_d;
    logic                          wb_valid_q, wb_valid_d;
    logic [REG_ADDRESS_LENGTH-1:0] wb_rd_q, wb_rd_d;
    logic                          wb_wr_en_q, wb_wr_en_d;

    logic     ex_match_a, ex_match_b;
    fwd_sel_e fwd_a, fwd_b;
    logic     mem_stall, load_use, exwb_en;

    hazard_match #(.REG_ADDRESS_LENGTH(REG_ADDRESS_LENGTH), .R0_ZERO(R0_ZERO)) u_match_a (
        .used(id_ra_used), .src(id_ra),
        .ex_valid(ex_valid_q), .ex_wr_en(ex_wr_en_q), .ex_rd(ex_rd_q),
        .wb_valid(wb_valid_q), .wb_wr_en(wb_wr_en_q), .wb_rd(wb_rd_q),
        .ex_match(ex_match_a), .fwd_sel(fwd_a)
    );

    hazard_match #(.REG_ADDRESS_LENGTH(REG_ADDRESS_LENGTH), .R0_ZERO(R0_ZERO)) u_match_b (
        .used(id_rb_used), .src(id_rb),
        .ex_valid(ex_valid_q), .ex_wr_en(ex_wr_en_q), .ex_rd(ex_rd_q),
        .wb_valid(wb_valid_q), .wb_wr_en(wb_wr_en_q), .wb_rd(wb_rd_q),
        .ex_match(ex_match_b), .fwd_sel(fwd_b)
    );

    assign fwd_a_sel    = fwd_a;
    assign fwd_b_sel    = fwd_b;
    assign stall_cycles = stall_cnt_q;

    // A load only blocks its consumer during its first cycle in EX; once it
    // has been held there (or moved on) the data is forwardable.
    assign mem_stall = (state_q != ERROR) & ex_valid_q & ex_is_mem_q & ~mem_ready;
    assign load_use  = (LOAD_LATENCY == 1) & id_valid & ex_valid_q & ex_is_load_q
                     & ~ex_age_q & (ex_match_a | ex_match_b);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exwb_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exwb_bubble = 1'b0;
        br_commit   = 1'b0;
        err         = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (int'(wait_cnt_d) == MEM_TIMEOUT) begin
                        state_d    = ERROR;
                        wait_cnt_d = '0;
                    end
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (state_q == ERROR) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            exwb_en = 1'b0;
            err     = 1'b1;
        end else if (mem_stall) begin
            // Bubbling WB while EX is held retires the access exactly once.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exwb_bubble = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            br_commit  = br_taken & id_valid;
            ifid_flush = br_commit;
        end
    end

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rd_d      = ex_rd_q;
        ex_wr_en_d   = ex_wr_en_q;
        ex_is_load_d = ex_is_load_q;
        ex_is_mem_d  = ex_is_mem_q;
        ex_age_d     = ex_age_q;
        wb_valid_d   = wb_valid_q;
        wb_rd_d      = wb_rd_q;
        wb_wr_en_d   = wb_wr_en_q;
        stall_cnt_d  = stall_cnt_q;

        if (exwb_en) begin
            if (exwb_bubble) begin
                wb_valid_d = 1'b0;
                wb_wr_en_d = 1'b0;
            end else begin
                wb_valid_d = ex_valid_q;
                wb_rd_d    = ex_rd_q;
                wb_wr_en_d = ex_wr_en_q;
            end
        end

        if (idex_en) begin
            ex_age_d = 1'b0;
            if (idex_bubble) begin
                ex_valid_d   = 1'b0;
                ex_rd_d      = '0;
                ex_wr_en_d   = 1'b0;
                ex_is_load_d = 1'b0;
                ex_is_mem_d  = 1'b0;
            end else begin
                ex_valid_d   = id_valid;
                ex_rd_d      = id_rd;
                ex_wr_en_d   = id_wr_en;
                ex_is_load_d = id_is_load;
                ex_is_mem_d  = id_is_mem;
            end
        end else begin
            ex_age_d = 1'b1;
        end

        if (!pc_en && (state_q != ERROR) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            ex_valid_q   <= 1'b0;
            ex_rd_q      <= '0;
            ex_wr_en_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_is_mem_q  <= 1'b0;
            ex_age_q     <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_wr_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            ex_valid_q   <= ex_valid_d;
            ex_rd_q      <= ex_rd_d;
            ex_wr_en_q   <= ex_wr_en_d;
            ex_is_load_q <= ex_is_load_d;
            ex_is_mem_q  <= ex_is_mem_d;
            ex_age_q     <= ex_age_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_wr_en_q   <= wb_wr_en_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios then
// random traffic, checked against a slot-level pipeline model.
module tb_pipeline_hazard_ctrl;

    localparam int RW = 5;
    localparam int LL = 1;
    localparam int MT = 4;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          id_valid, id_ra_used, id_rb_used, id_wr_en, id_is_load, id_is_mem;
    logic [RW-1:0] id_ra, id_rb, id_rd;
    logic          br_taken, mem_ready;
    logic          pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, exwb_bubble;
    logic          br_commit, err;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [SW-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDRESS_LENGTH(RW), .LOAD_LATENCY(LL), .R0_ZERO(1'b1),
        .MEM_TIMEOUT(MT), .STALL_CNT_W(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
        .id_ra_used(id_ra_used), .id_rb_used(id_rb_used),
        .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_is_mem(id_is_mem),
        .br_taken(br_taken), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exwb_bubble(exwb_bubble),
        .br_commit(br_commit), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .err(err), .stall_cycles(stall_cycles)
    );

    typedef struct {
        bit          rst_n;
        bit          idv;
        bit [RW-1:0] ra, rb, rd;
        bit          rau, rbu, we, ld, mem, br, mrdy;
    } stim_t;

    typedef struct {
        bit          pc_en, ifid_en, idex_en, ifid_flush, idex_bubble, exwb_bubble, br_commit, err;
        bit [1:0]    fa, fb;
        bit [SW-1:0] stalls;
    } exp_t;

    typedef struct {
        bit          v;
        bit [RW-1:0] rd;
        bit          we, ld, mem, held;
    } slot_t;

    exp_t  exp_q[$];
    slot_t m_ex, m_wb;
    bit    m_err, m_wait;
    int    m_wait_cnt, m_stalls;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    txn      = 0;

    // Where an operand comes from, judged from what the model holds in EX/WB.
    function automatic bit [1:0] model_fwd(bit used, bit [RW-1:0] a);
        if (!used || a == 0) return 2'd0;
        if (m_ex.v && m_ex.we && m_ex.rd == a) return 2'd1;
        if (m_wb.v && m_wb.we && m_wb.rd == a) return 2'd2;
        return 2'd0;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        s.rst_n = 1'b1;
        s.mrdy  = 1'b1;
        return s;
    endfunction

    function automatic stim_t ins(bit [RW-1:0] rd, bit we, bit ld, bit mem,
                                  bit [RW-1:0] ra, bit rau, bit [RW-1:0] rb, bit rbu,
                                  bit br, bit mrdy);
        stim_t s;
        s = nop();
        s.idv = 1'b1; s.rd = rd; s.we = we; s.ld = ld; s.mem = mem;
        s.ra = ra; s.rau = rau; s.rb = rb; s.rbu = rbu; s.br = br; s.mrdy = mrdy;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s = nop();
        s.idv  = $urandom_range(0, 3) != 0;
        s.ra   = RW'($urandom_range(0, 3));
        s.rb   = RW'($urandom_range(0, 3));
        s.rd   = RW'($urandom_range(0, 3));
        s.rau  = $urandom_range(0, 2) != 0;
        s.rbu  = $urandom_range(0, 2) != 0;
        s.we   = $urandom_range(0, 3) != 0;
        s.ld   = $urandom_range(0, 3) == 0;
        s.mem  = s.ld || ($urandom_range(0, 5) == 0);
        s.br   = $urandom_range(0, 3) == 0;
        s.mrdy = $urandom_range(0, 3) != 0;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t  e;
        bit    memst, lu, ex_hit;
        slot_t nx_ex, nx_wb;
        @(posedge clk);
        #1;
        rst        = s.rst_n;
        id_valid   = s.idv;
        id_ra      = s.ra;
        id_rb      = s.rb;
        id_ra_used = s.rau;
        id_rb_used = s.rbu;
        id_rd      = s.rd;
        id_wr_en   = s.we;
        id_is_load = s.ld;
        id_is_mem  = s.mem;
        br_taken   = s.br;
        mem_ready  = s.mrdy;
        if (!s.rst_n) begin
            m_ex = '{default: 0};
            m_wb = '{default: 0};
            m_err = 0; m_wait = 0; m_wait_cnt = 0; m_stalls = 0;
        end
        memst  = !m_err && m_ex.v && m_ex.mem && !s.mrdy;
        ex_hit = (model_fwd(s.rau, s.ra) == 2'd1) || (model_fwd(s.rbu, s.rb) == 2'd1);
        lu     = (LL == 1) && !m_err && !memst && s.idv && m_ex.ld && !m_ex.held && ex_hit;
        e.pc_en       = !m_err && !memst && !lu;
        e.ifid_en     = e.pc_en;
        e.idex_en     = !m_err && !memst;
        e.idex_bubble = lu;
        e.exwb_bubble = memst;
        e.br_commit   = s.br && s.idv && e.pc_en;
        e.ifid_flush  = e.br_commit;
        e.err         = m_err;
        e.fa          = model_fwd(s.rau, s.ra);
        e.fb          = model_fwd(s.rbu, s.rb);
        e.stalls      = SW'(m_stalls);
        exp_q.push_back(e);
        if (s.rst_n && !m_err) begin
            if (!e.pc_en && m_stalls < (1 << SW) - 1) m_stalls++;
            nx_wb = memst ? '{default: 0} : m_ex;
            if (memst) begin
                nx_ex = m_ex;
                nx_ex.held = 1;
            end else if (lu) begin
                nx_ex = '{default: 0};
            end else begin
                nx_ex = '{v: s.idv, rd: s.rd, we: s.we, ld: s.ld, mem: s.mem, held: 0};
            end
            if (memst) begin
                if (m_wait) begin
                    m_wait_cnt++;
                    if (MT != 0 && m_wait_cnt == MT) m_err = 1;
                end else begin
                    m_wait = 1;
                end
            end else begin
                m_wait = 0;
                m_wait_cnt = 0;
            end
            m_ex = nx_ex;
            m_wb = nx_wb;
        end
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL txn %0d %s: got %0d expected %0d", txn, name, act, expv);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc_en",       pc_en,        e.pc_en);
                check("ifid_en",     ifid_en,      e.ifid_en);
                check("idex_en",     idex_en,      e.idex_en);
                check("ifid_flush",  ifid_flush,   e.ifid_flush);
                check("idex_bubble", idex_bubble,  e.idex_bubble);
                check("exwb_bubble", exwb_bubble,  e.exwb_bubble);
                check("br_commit",   br_commit,    e.br_commit);
                check("fwd_a_sel",   fwd_a_sel,    e.fa);
                check("fwd_b_sel",   fwd_b_sel,    e.fb);
                check("err",         err,          e.err);
                check("stall_cyc",   stall_cycles, e.stalls);
                if (txn < 60)
                    $display("txn %0d: pc_en=%0b bub=%0b/%0b br=%0b fwd=%0d/%0d err=%0b stalls=%0d",
                             txn, pc_en, idex_bubble, exwb_bubble, br_commit,
                             fwd_a_sel, fwd_b_sel, err, stall_cycles);
                txn++;
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        m_ex = '{default: 0};
        m_wb = '{default: 0};
        m_err = 0; m_wait = 0; m_wait_cnt = 0; m_stalls = 0;
        s = nop();
        s.rst_n = 0;
        step(s); step(s);
        step(nop()); step(nop());
        // EX forwarding on A only
        step(ins(3, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        step(ins(0, 0, 0, 0, 3, 1, 5, 1, 0, 1));
        // EX beats WB; r0 never forwards
        step(ins(7, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        step(ins(7, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        step(ins(0, 0, 0, 0, 7, 1, 0, 0, 0, 1));
        step(ins(0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        step(ins(0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        step(ins(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        // load-use with a taken branch held in ID
        step(ins(4, 1, 1, 1, 0, 0, 0, 0, 0, 1));
        s = ins(0, 0, 0, 0, 4, 1, 0, 0, 1, 1);
        step(s); step(s);
        step(nop());
        // slow memory: three frozen cycles
        step(ins(6, 1, 0, 1, 0, 0, 0, 0, 0, 1));
        s = ins(0, 0, 0, 0, 6, 1, 0, 0, 1, 0);
        step(s); step(s); step(s);
        s.mrdy = 1;
        step(s);
        step(nop());
        // watchdog timeout, then reset out of ERROR
        step(ins(6, 1, 0, 1, 0, 0, 0, 0, 0, 1));
        s = nop();
        s.mrdy = 0;
        repeat (8) step(s);
        s.rst_n = 0;
        step(s);
        step(nop()); step(nop());
        // plain taken branch
        s = nop();
        s.idv = 1; s.br = 1;
        step(s);
        for (int i = 0; i < 3000; i++) begin
            s = rnd();
            if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
                s.rst_n = 0;
            step(s);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard, stall and flush controller for the 4-stage core (IF, ID, EX/MEM, WB). It generalises the single-source ID-stage forwarding to two sources (EX and WB) and adds load-use interlock for configurable load latency, freeze on slow DMEM/NIC accesses with a timeout watchdog, and gated branch commit. It tracks per-stage valid/destination state internally and drives all stage-register enables and bubble/flush controls.

## Interface
- REG_ADDRESS_LENGTH, 5, register address width
- LOAD_LATENCY, 0, extra cycles before load data is forwardable (0 or 1)
- R0_ZERO, 1, register 0 is never a hazard or forward source
- MEM_TIMEOUT, 64, MEM_WAIT cycles before ERROR; 0 disables the watchdog
- STALL_CNT_W, 16, stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_ra, id_rb  in  REG_ADDRESS_LENGTH  ID source addresses
- id_ra_used, id_rb_used  in  1  source is actually read
- id_rd  in  REG_ADDRESS_LENGTH  ID destination
- id_wr_en  in  1  ID instruction writes id_rd
- id_is_load  in  1  DMEM or NIC load
- id_is_mem  in  1  any DMEM/NIC access
- br_taken  in  1  branch unit resolves taken in ID
- mem_ready  in  1  DMEM/NIC completes the EX access this cycle
- pc_en, ifid_en, idex_en  out  1  stage-register enables
- ifid_flush  out  1  load zero into IF/ID
- idex_bubble  out  1  load a bubble (valid=0, wr_en=0) into ID/EX
- exwb_bubble  out  1  load a bubble into EX/WB
- br_commit  out  1  PC takes the branch target
- fwd_a_sel, fwd_b_sel  out  2  0 regfile, 1 EX result, 2 WB result
- err  out  1  watchdog fired
- stall_cycles  out  STALL_CNT_W  saturating stall counter

## Operation
- Internal tracking registers: ex_{valid, rd, wr_en, is_load, is_mem, age} and wb_{valid, rd, wr_en}. They advance with idex_en/exwb_en and take the same bubble semantics as the datapath.
- Match on operand x: used_x & valid & wr_en & rd==x & !(R0_ZERO & x==0).
- Forwarding select:
  - EX match → 1.
  - Otherwise WB match → 2.
  - Otherwise 0.
  - EX wins over WB.
- Load-use: if LOAD_LATENCY=1 and EX is a load matching either used source, ID stalls for one cycle. EX then advances into WB and the operand forwards with select 2.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN → MEM_WAIT when ex_valid & ex_is_mem & !mem_ready.
  - MEM_WAIT → RUN on mem_ready.
  - MEM_WAIT → ERROR when the wait count reaches MEM_TIMEOUT (if nonzero).
  - ERROR is left only by reset.
- Priority (highest first): ERROR, then mem wait, then load-use, then branch.
  - ERROR: all enables 0, err=1.
  - Mem wait (RUN with a pending access, or MEM_WAIT): pc_en=ifid_en=idex_en=0, exwb_bubble=1 so a WB write occurs exactly once.
  - Load-use: pc_en=ifid_en=0, idex_bubble=1.
  - Branch: br_commit=br_taken & id_valid & no stall; ifid_flush=br_commit.
- Normal: all enables 1, bubbles 0.
- stall_cycles increments (saturating at all-ones) each cycle pc_en=0 outside ERROR.

## Timing
- All outputs are combinational from the inputs and tracking registers; there is no added latency.
- Reset values: tracking valids 0, FSM in RUN, wait count 0, stall_cycles 0, err 0. With no valid instructions, enables are 1 and fwd selects are 0.
- mem_ready in the same cycle the access enters EX means no stall.
- A load-use stall and a taken branch in the same cycle: the stall wins and br_commit=0. The branch re-evaluates the next cycle.
- Reset asserted mid-MEM_WAIT or in ERROR: immediate return to RUN with all tracking cleared.
- Wait count clears on leaving MEM_WAIT.

## Structure
- Package pipeline_pkg holds:
  - fwd_sel encoding: FWD_RF=0, FWD_EX=1, FWD_WB=2.
  - FSM state enum.
- Sub-module hazard_match: one instance per source operand, outputs the ex/wb match and fwd_sel. The top holds the FSM, the tracking registers and the counters.

## Test plan
- EX writes r3, ID reads r3 on A, r5 on B → fwd_a_sel=1, fwd_b_sel=0, no stall.
- EX and WB both write r7, ID reads r7 → fwd_a_sel=1. With r0 in place of r7 and R0_ZERO=1 → fwd_a_sel=0.
- LOAD_LATENCY=1, EX is a load to r4, ID reads r4 → one cycle with pc_en=0, idex_bubble=1; next cycle fwd=2, stall_cycles=1.
- EX mem op with mem_ready low for 3 cycles → 3 frozen cycles, exwb_bubble=1, then RUN; stall_cycles=3.
- MEM_TIMEOUT=4, mem_ready held low → err=1 after 4 wait cycles, all enables 0; rst low then high → err=0, RUN.
- br_taken with id_valid and no hazard → br_commit=1, ifid_flush=1. The same branch during a load-use stall → br_commit=0.
